// File: rtl/rnd_8_if.sv
// Bus bundle for the rnd_8 pseudo-random byte source.
// The master side drives the enable/load/seed controls and the slave side returns the random byte.
interface rnd_8_if;
  logic        en;
  logic        load;
  logic [15:0] seed;
  logic [7:0]  out;

  modport master (output en, output load, output seed, input out);
  modport slave  (input en, input load, input seed, output out);
endinterface

// File: rtl/rnd_8.sv
// 8-bit pseudo-random byte source: a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) that advances 8 steps per enabled clock.
// Optional macro RND8_WHITEN_EN folds the high byte into the output; the state sequence is the same in both builds.
module rnd_8 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic     clk,
  input  logic     rst,
  rnd_8_if.slave   bus
);

  // A zero seed would lock the LFSR, so it falls back to the known-good default.
  localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  logic [15:0] state;
  logic [15:0] state_next;
  logic [15:0] stepped;

  always_comb begin
    stepped = state;
    for (int i = 0; i < 8; i++) begin
      stepped = {stepped[14:0], stepped[15] ^ stepped[13] ^ stepped[12] ^ stepped[10]};
    end
  end

  // The lock-up recovery outranks everything else, and a load outranks stepping.
  always_comb begin
    state_next = state;
    if (state == 16'h0000) begin
      state_next = SEED_SAFE;
    end else if (bus.load) begin
      state_next = (bus.seed == 16'h0000) ? SEED_SAFE : bus.seed;
    end else if (bus.en) begin
      state_next = stepped;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED_SAFE;
    end else begin
      state <= state_next;
    end
  end

`ifdef RND8_WHITEN_EN
  assign bus.out = state[7:0] ^ state[15:8];
`else
  assign bus.out = state[7:0];
`endif

endmodule

// File: tb/tb_rnd_8.sv
// Self-checking bench for rnd_8: vector table, randomized scoreboard run, reset corners and full-period sweep.
module tb_rnd_8;

  logic clk = 1'b0;
  logic rst;

  rnd_8_if bus ();

  rnd_8 #(.SEED(16'hACE1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        load;
    logic [15:0] seed;
    logic [15:0] exp_state;
    string       name;
  } vec_t;

  vec_t        vecs[12];
  logic [15:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          fails  = 0;
  logic [15:0] model;

  // Model uses the bit-sequence form: a[0] is the oldest bit (s[15]).
  function automatic logic [15:0] model_step8(input logic [15:0] s);
    logic a[24];
    logic [15:0] r;
    for (int k = 0; k < 16; k++) a[k] = s[15-k];
    for (int n = 0; n < 8; n++) a[n+16] = a[n] ^ a[n+2] ^ a[n+3] ^ a[n+5];
    for (int k = 0; k < 16; k++) r[15-k] = a[k+8];
    return r;
  endfunction

  function automatic logic [15:0] model_next(input logic [15:0] s, input logic en,
                                             input logic load, input logic [15:0] seed);
    if (s == 16'h0000) return 16'hACE1;
    if (load) return (seed == 16'h0000) ? 16'hACE1 : seed;
    if (en) return model_step8(s);
    return s;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic load, input logic [15:0] seed,
                               input logic [15:0] exp_state, input string name);
    @(negedge clk);
    bus.en   = en;
    bus.load = load;
    bus.seed = seed;
    exp_q.push_back(exp_state);
    name_q.push_back(name);
    model = exp_state;
  endtask

  task automatic checkOutput();
    logic [15:0] exp;
    string       name;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL scoreboard: queue empty, got 0x%04h, expected an entry", dut.state);
    end else begin
      exp  = exp_q.pop_front();
      name = name_q.pop_front();
      check({name, " state"}, dut.state, exp);
      check({name, " out"}, {8'h00, bus.out}, {8'h00, exp[7:0]});
    end
  endtask

  initial begin
    int          cycles;
    int          mism;
    int          zero_seen;
    logic        ren;
    logic        rload;
    logic [15:0] rseed;
    logic [15:0] nxt;

    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 16'hE1E4, "step1"};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 16'hE1E4, "hold1"};
    vecs[2]  = '{1'b0, 1'b0, 16'h5555, 16'hE1E4, "hold2"};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 16'hE1E4, "hold3"};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 16'hE1E4, "hold4"};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 16'hE1E4, "hold5"};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 16'hE455, "resume"};
    vecs[7]  = '{1'b1, 1'b1, 16'h1234, 16'h1234, "load_1234"};
    vecs[8]  = '{1'b1, 1'b1, 16'h0000, 16'hACE1, "load_zero"};
    vecs[9]  = '{1'b1, 1'b0, 16'h0000, 16'hE1E4, "step_after_load"};
    vecs[10] = '{1'b0, 1'b1, 16'hBEEF, 16'hBEEF, "load_no_en"};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 16'hBEEF, "hold_beef"};

    rst      = 1'b0;
    bus.en   = 1'b0;
    bus.load = 1'b0;
    bus.seed = 16'h0000;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("async_reset out", {8'h00, bus.out}, 16'h00E1);
    check("async_reset state", dut.state, 16'hACE1);
    @(negedge clk);
    rst = 1'b0;
    model = 16'hACE1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].en, vecs[i].load, vecs[i].seed, vecs[i].exp_state, vecs[i].name);
      checkOutput();
    end

    // Randomized traffic with model-predicted expectations.
    for (int i = 0; i < 150; i++) begin
      ren   = 1'($urandom_range(0, 1));
      rload = ($urandom_range(0, 9) == 0);
      rseed = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      nxt   = model_next(model, ren, rload, rseed);
      applyStimulus(ren, rload, rseed, nxt, "random");
      checkOutput();
    end

    // Reset asserted between edges while stepping.
    @(negedge clk);
    bus.en   = 1'b1;
    bus.load = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_reset out", {8'h00, bus.out}, 16'h00E1);
    check("midrun_reset state", dut.state, 16'hACE1);
    @(posedge clk);
    #1;
    check("reset_held state", dut.state, 16'hACE1);
    @(negedge clk);
    bus.en = 1'b0;
    rst    = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'hE1E4, "post_reset_step1");
    checkOutput();
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'hE455, "post_reset_step2");
    checkOutput();

    // Full period sweep from reset.
    @(negedge clk);
    rst    = 1'b1;
    bus.en = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    model     = 16'hACE1;
    cycles    = 0;
    mism      = 0;
    zero_seen = 0;
    while (cycles < 70000) begin
      @(posedge clk);
      #1;
      cycles++;
      model = model_step8(model);
      if (dut.state !== model) mism++;
      if (dut.state == 16'h0000) zero_seen++;
      if (dut.state == 16'hACE1) break;
    end
    check("period length", 16'(cycles), 16'(65535));
    check("period model mismatches", 16'(mism), 16'd0);
    check("period zero states", 16'(zero_seen), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rnd_8.md
Name: rnd_8

Overview:
- 8-bit pseudo-random byte source for the synth modulation path; its consumer samples one byte per clock.
- Built on a 16-bit maximal-length Fibonacci LFSR that advances 8 bit-steps per enabled clock, so each output byte is 8 freshly generated bits.
- Supports a synchronous seed load and protects against LFSR lock-up.

Parameters:
- SEED, 16'hACE1, reset and fallback state of the LFSR; must be nonzero. A zero SEED is a configuration error; the generator then uses 16'hACE1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  advance enable; 1 = step LFSR this clock.
- load  input  1  synchronous seed load strobe.
- seed  input  16  seed value captured when load=1.
- out  output  8  current random byte, registered.

Behaviour:
- State s[15:0]; out = s[7:0] combinationally from the register, so no extra latency.
- Reset (rst=1, asynchronous): s = SEED immediately. out = SEED[7:0] (0xE1 at default). State holds while rst is high.
- Single step: fb = s[15]^s[13]^s[12]^s[10]; s_next = {s[14:0], fb}.
  - Polynomial: x^16+x^14+x^13+x^11+1, period 65535.
- Per clock, when en=1 and load=0: apply the single step 8 times combinationally (unrolled) and register the result.
  - Equivalent bit-sequence form: a[n+16] = a[n]^a[n+2]^a[n+3]^a[n+5], with s[15] the oldest bit.
- Byte period: 65535 clocks (65535 is coprime with 8). Each nonzero state appears exactly once per period.
- Load, when load=1: next s = seed. If seed==0, next s = SEED.
  - Load has priority over en. No stepping occurs in the load cycle.
  - out shows the new seed's low byte on the following cycle.
- Hold: en=0 and load=0 keeps s unchanged.
- Lock-up guard: if s is ever 0 (e.g. upset), the next clock loads SEED regardless of en.
- Reset deasserted mid-operation: stepping resumes from SEED on the first rising edge after release.
- No handshake. The consumer may sample out every cycle.

Optional Feature:
- Macro RND8_WHITEN_EN.
  - Defined: out = s[7:0] ^ s[15:8]. Default reset out = 0xE1^0xAC = 0x4D; after one enabled clock = 0xE4^0xE1 = 0x05.
  - Undefined: out = s[7:0]. The state sequence is identical in both builds.
- All test values below assume the macro is undefined.

Test Plan:
- Reset: assert rst asynchronously with no clock edge -> out = 0xE1 immediately, internal state 0xACE1.
- Stepping: release rst, en=1, two clocks -> state 0xE1E4 / out 0xE4, then state 0xE455 / out 0x55.
- Hold: en=0 for 5 clocks after out = 0xE4 -> out stays 0xE4. Raising en resumes with 0x55.
- Load: load=1, seed=16'h1234, en=1 -> next out = 0x34, no step that cycle. load=1 with seed=0 -> state 0xACE1, out 0xE1.
- Period: from reset, en=1 continuously -> state returns to 0xACE1 after exactly 65535 clocks, never 0, no earlier repeat.
- Mid-run reset: assert rst between edges during stepping -> out = 0xE1 at once. Sequence after release matches the stepping scenario.
